// File: rtl/svf_coef_sequencer.sv
// Coefficient sequencer for the 8-bit state-variable filter: sample-rate strobe,
// alpha1 glide toward a programmed cutoff, and alpha2 damping, all updated on strobe edges.
module svf_coef_sequencer #(
    parameter int CLK_DIV      = 15,
    parameter int SLEW_STEP    = 8,
    parameter int RESET_ALPHA1 = 1024,
    parameter int RESET_ALPHA2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] cutoff_target,
    input  logic [1:0]  res_target,
    input  logic        coef_load,
    input  logic        glide_en,
    output logic        sample_valid,
    output logic [10:0] alpha1,
    output logic [1:0]  alpha2,
    output logic        busy
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [10:0] STEP     = 11'(SLEW_STEP);
    localparam logic [10:0] A1_RST   = 11'(RESET_ALPHA1);
    localparam logic [1:0]  A2_RST   = 2'(RESET_ALPHA2);

    typedef enum logic {IDLE, GLIDE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] presc;
    logic [10:0] tgt_a1;
    logic [1:0]  tgt_a2;
    logic [10:0] alpha1_d;

    // One bounded step toward tgt; lands exactly on tgt when within reach, so no overshoot.
    function automatic logic [10:0] slew_toward(input logic [10:0] cur, input logic [10:0] tgt);
        logic signed [11:0] diff;
        logic        [11:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[11] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= {1'b0, STEP})
            slew_toward = tgt;
        else if (diff[11])
            slew_toward = cur - STEP;
        else
            slew_toward = cur + STEP;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (presc == DIV_LAST);
            presc        <= (presc == DIV_LAST) ? '0 : presc + 16'd1;
        end
    end

    // alpha1 = 0 would freeze the filter, so a zero request is clamped to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_a1 <= A1_RST;
            tgt_a2 <= A2_RST;
        end else if (coef_load) begin
            tgt_a1 <= (cutoff_target == 11'd0) ? 11'd1 : cutoff_target;
            tgt_a2 <= res_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alpha1  <= A1_RST;
            alpha2  <= A2_RST;
        end else begin
            state_q <= state_d;
            alpha1  <= alpha1_d;
            if (sample_valid)
                alpha2 <= tgt_a2;
        end
    end

    // alpha1 only moves on a strobe edge; a retarget onto the current value ends the glide early.
    always_comb begin
        state_d  = state_q;
        alpha1_d = alpha1;
        case (state_q)
            IDLE: begin
                if (alpha1 != tgt_a1)
                    state_d = GLIDE;
            end
            GLIDE: begin
                if (sample_valid) begin
                    alpha1_d = glide_en ? slew_toward(alpha1, tgt_a1) : tgt_a1;
                    if (alpha1_d == tgt_a1)
                        state_d = IDLE;
                end else if (alpha1 == tgt_a1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == GLIDE);

endmodule

// File: tb/tb_svf_coef_sequencer.sv
// Scoreboard bench for svf_coef_sequencer: expected per-strobe coefficient sets are queued
// up front, and a monitor checks each strobe's values and its timing against the queue.
module tb_svf_coef_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int SLEW_STEP = 8;

    logic        clk;
    logic        rst_n;
    logic [10:0] cutoff_target;
    logic [1:0]  res_target;
    logic        coef_load;
    logic        glide_en;
    logic        sample_valid;
    logic [10:0] alpha1;
    logic [1:0]  alpha2;
    logic        busy;

    typedef struct {
        int a1;
        int a2;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_exp = CLK_DIV;
    int   strobe_no = 0;

    svf_coef_sequencer #(
        .CLK_DIV(CLK_DIV),
        .SLEW_STEP(SLEW_STEP),
        .RESET_ALPHA1(1024),
        .RESET_ALPHA2(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cutoff_target(cutoff_target),
        .res_target(res_target),
        .coef_load(coef_load),
        .glide_en(glide_en),
        .sample_valid(sample_valid),
        .alpha1(alpha1),
        .alpha2(alpha2),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s strobe=%0d got %0d expected %0d", name, strobe_no, act, exp);
        end
    endtask

    task automatic push(input int a1, input int a2, input int b);
        exp_t e;
        e.a1 = a1;
        e.a2 = a2;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must arrive on period and carry the next queued coefficient set.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            next_exp = CLK_DIV;
        end else begin
            cyc++;
            if (sample_valid) begin
                exp_t e;
                strobe_no++;
                chk("strobe_period", cyc, next_exp);
                next_exp += CLK_DIV;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe strobe=%0d alpha1=%0d", strobe_no, alpha1);
                end else begin
                    e = exp_q.pop_front();
                    chk("alpha1", int'(alpha1), e.a1);
                    chk("alpha2", int'(alpha2), e.a2);
                    chk("busy", int'(busy), e.busy);
                end
            end
        end
    end

    // Returns just after the clk edge that ends the next strobe cycle.
    task automatic next_update();
        bit seen = 0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout got none expected strobe within %0d cycles", 4 * CLK_DIV);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int cut, input int res);
        cutoff_target = 11'(cut);
        res_target    = 2'(res);
        coef_load     = 1'b1;
        @(posedge clk);
        #1;
        coef_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cutoff_target = '0;
        res_target = '0;
        coef_load = 1'b0;
        glide_en = 1'b0;

        // Jump, jump back, glide up to 1050, glide toward 1100 then retarget to 0 (clamped to 1),
        // coincident load to 200, then a glide interrupted by reset.
        push(1024, 2, 0);
        push(1024, 2, 1);
        push(100, 3, 1);
        push(1024, 2, 1);
        push(1032, 2, 1);
        push(1040, 2, 1);
        push(1048, 2, 1);
        push(1050, 2, 0);
        push(1050, 2, 1);
        push(1058, 1, 1);
        push(1066, 1, 1);
        for (int k = 1; k <= 133; k++)
            push(1066 - 8 * k, 0, 1);
        push(1, 0, 0);
        push(1, 0, 0);
        push(1, 0, 1);
        push(200, 3, 0);
        push(200, 3, 1);
        push(208, 1, 1);

        repeat (3) @(negedge clk);
        chk("rst_alpha1", int'(alpha1), 1024);
        chk("rst_alpha2", int'(alpha2), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        #1 rst_n = 1'b1;

        next_update();
        pulse_load(100, 3);
        next_update();
        pulse_load(1024, 2);

        next_update();
        glide_en = 1'b1;
        pulse_load(1050, 2);

        repeat (5) next_update();
        pulse_load(1100, 1);
        repeat (2) next_update();
        pulse_load(0, 0);

        repeat (135) next_update();
        glide_en = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 4 * CLK_DIV; i++) begin
                @(negedge clk);
                if (sample_valid) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL strobe_timeout got none expected strobe within %0d cycles", 4 * CLK_DIV);
            end
            cutoff_target = 11'd200;
            res_target = 2'd3;
            coef_load = 1'b1;
            @(posedge clk);
            #1;
            coef_load = 1'b0;
        end

        repeat (2) next_update();
        glide_en = 1'b1;
        pulse_load(600, 1);
        repeat (2) next_update();

        chk("queue_drained_before_reset", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_alpha1", int'(alpha1), 1024);
        chk("async_rst_alpha2", int'(alpha2), 2);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_sample_valid", int'(sample_valid), 0);

        push(1024, 2, 0);
        push(1024, 2, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) next_update();
        @(negedge clk);
        chk("queue_drained_at_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/svf_coef_sequencer.md
Name: svf_coef_sequencer

Overview:
Control-side driver for the 8-bit state-variable filter. It generates the filter's sample_valid strobe from a clock prescaler, and supplies the alpha1 (frequency) and alpha2 (damping) coefficients. alpha1 glides toward a programmed target at a bounded rate per sample, which prevents zipper noise on cutoff sweeps. Coefficients change only between filter updates, so the filter always sees a stable set for the whole sample period.

Parameters:
CLK_DIV, 15, clocks per sample period; sample rate = clk / CLK_DIV; legal range 2..65535
SLEW_STEP, 8, maximum change of alpha1 per sample strobe while gliding; legal range 1..2047
RESET_ALPHA1, 1024, alpha1 value after reset; legal range 1..2047
RESET_ALPHA2, 2, alpha2 value after reset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cutoff_target  input  11  requested alpha1; sampled only when coef_load=1
res_target  input  2  requested alpha2; sampled only when coef_load=1
coef_load  input  1  single-cycle pulse; captures both targets
glide_en  input  1  1 = slew alpha1 toward target; 0 = jump to target
sample_valid  output  1  one-clk strobe per sample period; drives the filter's sample_valid
alpha1  output  11  registered frequency coefficient to the filter
alpha2  output  2  registered damping coefficient to the filter
busy  output  1  1 while alpha1 differs from the captured cutoff target

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n. All state clears immediately when rst_n falls, independent of clk.
- Reset values:
  - prescaler = 0, sample_valid = 0
  - alpha1 = RESET_ALPHA1, alpha2 = RESET_ALPHA2
  - tgt_a1 = RESET_ALPHA1, tgt_a2 = RESET_ALPHA2
  - state = IDLE, busy = 0
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - sample_valid is registered and high for exactly one cycle, in the cycle after the counter reaches CLK_DIV-1.
  - The first strobe occurs CLK_DIV cycles after reset release. Period is exactly CLK_DIV, with no drift.
- Target capture: on a clk edge with coef_load=1:
  - tgt_a1 <= (cutoff_target==0 ? 1 : cutoff_target). alpha1=0 would freeze the filter, so 0 is clamped to 1.
  - tgt_a2 <= res_target.
  - coef_load is ignored when not pulsed; holding it high recaptures every cycle.
- Coefficient update timing:
  - alpha1 and alpha2 change only on the clk edge that ends a cycle with sample_valid=1.
  - They are therefore constant from the end of one strobe through the next strobe inclusive; the filter consumes a stable pair.
  - The update on a strobe edge uses the tgt_* values held before that edge. A coef_load coincident with the strobe cycle takes effect at the following strobe.
- alpha2: on each strobe edge, alpha2 <= tgt_a2. No glide.
- alpha1 FSM, states IDLE and GLIDE:
  - IDLE: when alpha1 != tgt_a1, go to GLIDE and set busy=1, on the capture edge +1.
  - GLIDE, glide_en=1: on each strobe edge, d = tgt_a1 - alpha1 (signed, 12-bit).
    - If |d| <= SLEW_STEP: alpha1 <= tgt_a1 and go to IDLE.
    - Otherwise: alpha1 <= alpha1 ± SLEW_STEP toward the target.
    - No overshoot; alpha1 never leaves 1..2047.
  - GLIDE, glide_en=0: on the next strobe edge, alpha1 <= tgt_a1 and go to IDLE.
  - Retarget during GLIDE (coef_load): the glide continues from the current alpha1 toward the new target. The direction may reverse. Stay in GLIDE unless alpha1 already equals the new target, in which case go to IDLE.
  - busy = (state==GLIDE). It deasserts on the same edge alpha1 reaches tgt_a1.
- Reset mid-glide: all outputs return to reset values asynchronously. The prescaler restarts from 0.
- Widths: the difference is computed at 12 bits signed and the step at 11 bits unsigned; no truncation is permitted.

Test Plan:
- Reset/strobe (CLK_DIV=4): release rst_n -> sample_valid high in cycles 4, 8, 12…, 1 clk wide; alpha1=1024, alpha2=2, busy=0.
- Jump (glide_en=0): load cutoff=100, res=3 -> at the next strobe end, alpha1=100 and alpha2=3; no change in between; busy=1 until that edge.
- Glide up (SLEW_STEP=8, alpha1=1024): load 1050 -> alpha1 steps 1032, 1040, 1048, 1050 on four consecutive strobes; busy drops with 1050.
- Zero clamp and reversal: load 0 mid-glide up -> direction reverses, decrementing by 8 per strobe and settling at exactly 1.
- Load coincident with strobe: coef_load in the sample_valid cycle -> the coefficients are unchanged at that strobe edge and updated at the next strobe edge.
- Async reset mid-glide: assert rst_n=0 between clk edges -> alpha1=1024, busy=0, sample_valid=0 immediately; the strobe restarts CLK_DIV cycles after release.
